// File: rtl/dmem_arbiter.sv
// dmem_arbiter: two-port arbiter/sequencer for the single-port data memory, with aging override and 1-cycle response
module dmem_arbiter #(
  parameter int DEPTH   = 512,
  parameter int AGE_MAX = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        core_req,
  input  logic        core_we,
  input  logic [31:0] core_addr,
  input  logic [31:0] core_wdata,
  output logic        core_gnt,
  output logic        core_rvalid,
  output logic [31:0] core_rdata,
  output logic        core_err,
  input  logic        aux_req,
  input  logic        aux_we,
  input  logic [31:0] aux_addr,
  input  logic [31:0] aux_wdata,
  output logic        aux_gnt,
  output logic        aux_rvalid,
  output logic [31:0] aux_rdata,
  output logic        aux_err,
  output logic        stall,
  output logic        MemWrite,
  output logic        MemRead,
  output logic [31:0] address,
  output logic [31:0] writeData,
  input  logic [31:0] readData
);
  logic [3:0] wait_cnt;
  logic age_hit, sel_we, any_gnt, oor, in_rng;
  logic [31:0] sel_addr, sel_wdata, rdata_q;
  // grants are masked by rst_n so every output reads 0 while reset is held
  always_comb begin
    age_hit   = aux_req & (wait_cnt >= 4'(AGE_MAX));
    core_gnt  = rst_n & core_req & ~age_hit;
    aux_gnt   = rst_n & aux_req & ~core_gnt;
    stall     = rst_n & core_req & ~core_gnt;
    any_gnt   = core_gnt | aux_gnt;
    sel_addr  = aux_gnt ? aux_addr : core_addr;
    sel_wdata = aux_gnt ? aux_wdata : core_wdata;
    sel_we    = aux_gnt ? aux_we : core_we;
    oor       = sel_addr >= 32'(DEPTH);
    in_rng    = any_gnt & ~oor;
    MemWrite  = in_rng & sel_we;
    MemRead   = in_rng & ~sel_we;
    address   = in_rng ? sel_addr : '0;
    writeData = in_rng ? sel_wdata : '0;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_cnt    <= '0;
      core_rvalid <= 1'b0;
      aux_rvalid  <= 1'b0;
      core_err    <= 1'b0;
      aux_err     <= 1'b0;
      rdata_q     <= '0;
    end else begin
      wait_cnt    <= (aux_req & ~aux_gnt) ? wait_cnt + {3'b0, wait_cnt != 4'hf} : '0;
      core_rvalid <= core_gnt;
      aux_rvalid  <= aux_gnt;
      core_err    <= core_gnt & oor;
      aux_err     <= aux_gnt & oor;
      rdata_q     <= MemRead ? readData : '0;
    end
  end
  assign core_rdata = core_rvalid ? rdata_q : '0;
  assign aux_rdata  = aux_rvalid ? rdata_q : '0;
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed scoreboard bench with a behavioural memory and reference arbitration model
module tb_dmem_arbiter;
  logic clk = 0, rst_n = 0;
  logic core_req = 0, core_we = 0, aux_req = 0, aux_we = 0;
  logic [31:0] core_addr = 0, core_wdata = 0, aux_addr = 0, aux_wdata = 0;
  logic core_gnt, core_rvalid, core_err, aux_gnt, aux_rvalid, aux_err, stall, MemWrite, MemRead;
  logic [31:0] core_rdata, aux_rdata, address, writeData, readData;
  logic [31:0] mem [0:511];
  logic [31:0] mmem [0:511];
  typedef struct {logic cv; logic av; logic ce; logic ae; logic [31:0] d;} rsp_t;
  rsp_t q[$];
  int total = 0, bad = 0, mw = 0, aux_wins = 0;

  dmem_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .core_req(core_req), .core_we(core_we), .core_addr(core_addr), .core_wdata(core_wdata),
    .core_gnt(core_gnt), .core_rvalid(core_rvalid), .core_rdata(core_rdata), .core_err(core_err),
    .aux_req(aux_req), .aux_we(aux_we), .aux_addr(aux_addr), .aux_wdata(aux_wdata),
    .aux_gnt(aux_gnt), .aux_rvalid(aux_rvalid), .aux_rdata(aux_rdata), .aux_err(aux_err),
    .stall(stall), .MemWrite(MemWrite), .MemRead(MemRead),
    .address(address), .writeData(writeData), .readData(readData)
  );

  always #5 clk = ~clk;
  assign readData = mem[address[8:0]];
  always @(posedge clk) if (MemWrite) mem[address[8:0]] <= writeData;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_rsp();
    rsp_t e = '{cv: 0, av: 0, ce: 0, ae: 0, d: 0};
    if (q.size() > 0) e = q.pop_front();
    chk("core_rvalid", core_rvalid, e.cv);
    chk("aux_rvalid", aux_rvalid, e.av);
    chk("core_err", core_err, e.ce);
    chk("aux_err", aux_err, e.ae);
    chk("core_rdata", core_rdata, e.cv ? e.d : 32'h0);
    chk("aux_rdata", aux_rdata, e.av ? e.d : 32'h0);
  endtask

  task automatic step(input logic cr, input logic cw, input logic [31:0] ca, input logic [31:0] cd,
                      input logic ar, input logic aw, input logic [31:0] aa, input logic [31:0] ad);
    logic cg, ag, we, inr;
    logic [31:0] a, d;
    @(negedge clk);
    check_rsp();
    core_req = cr; core_we = cw; core_addr = ca; core_wdata = cd;
    aux_req = ar; aux_we = aw; aux_addr = aa; aux_wdata = ad;
    #1;
    cg = cr && !(ar && mw >= 4);
    ag = ar && !cg;
    a = ag ? aa : ca;
    d = ag ? ad : cd;
    we = ag ? aw : cw;
    inr = (cg || ag) && a < 512;
    chk("core_gnt", core_gnt, cg);
    chk("aux_gnt", aux_gnt, ag);
    chk("stall", stall, cr && !cg);
    chk("MemWrite", MemWrite, inr && we);
    chk("MemRead", MemRead, inr && !we);
    chk("address", address, inr ? a : 32'h0);
    if (ag) aux_wins++;
    q.push_back('{cv: cg, av: ag, ce: cg && !inr, ae: ag && !inr,
                  d: (inr && !we) ? mmem[a[8:0]] : 32'h0});
    if (inr && we) mmem[a[8:0]] = d;
    mw = (ar && !ag) ? ((mw == 15) ? 15 : mw + 1) : 0;
  endtask

  task automatic idle();
    step(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic all_zero(input string tag);
    chk({tag, "_gnt"}, {core_gnt, aux_gnt, stall, MemWrite, MemRead}, 0);
    chk({tag, "_rvalid"}, {core_rvalid, aux_rvalid, core_err, aux_err}, 0);
    chk({tag, "_rdata"}, core_rdata | aux_rdata, 0);
  endtask

  initial begin
    for (int i = 0; i < 512; i++) begin
      mem[i] = 32'hA500_0000 | i;
      mmem[i] = 32'hA500_0000 | i;
    end
    #12;
    all_zero("reset");
    @(negedge clk) rst_n = 1;
    // port-0 write then read back
    step(1, 1, 5, 32'hDEADBEEF, 0, 0, 0, 0);
    step(1, 0, 5, 0, 0, 0, 0, 0);
    idle();
    // back-to-back reads
    for (int i = 0; i < 3; i++) step(1, 0, i, 0, 0, 0, 0, 0);
    idle();
    // sustained contention: 4:1 pattern
    aux_wins = 0;
    for (int i = 0; i < 10; i++) step(1, 0, 10 + i, 0, 1, 0, 20 + i, 0);
    chk("contention_aux_wins", aux_wins, 2);
    idle();
    // out-of-range accesses
    step(0, 0, 0, 0, 1, 1, 512, 32'h1234_5678);
    step(1, 0, 0, 0, 0, 0, 0, 0);
    step(1, 0, 600, 0, 1, 0, 32'hFFFF_FFFF, 0);
    step(0, 0, 0, 0, 1, 0, 511, 0);
    idle();
    // withdrawal clears the age counter
    for (int i = 0; i < 3; i++) step(1, 0, 30, 0, 1, 1, 40, 32'h77);
    step(1, 0, 30, 0, 0, 0, 0, 0);
    aux_wins = 0;
    for (int i = 0; i < 4; i++) step(1, 0, 30, 0, 1, 1, 40, 32'h77);
    chk("withdraw_no_early_win", aux_wins, 0);
    step(1, 0, 30, 0, 1, 1, 40, 32'h77);
    chk("withdraw_win_5th", aux_wins, 1);
    idle();
    // reset in the cycle after a granted read
    step(1, 0, 5, 0, 1, 0, 6, 0);
    @(posedge clk);
    #1 rst_n = 0;
    #1;
    chk("rst_core_rvalid", core_rvalid, 0);
    all_zero("in_reset");
    q.delete();
    mw = 0;
    core_req = 0; aux_req = 0;
    @(negedge clk) rst_n = 1;
    for (int i = 0; i < 5; i++) step(1, 0, 5, 0, 1, 0, 6, 0);
    idle();
    idle();
    @(negedge clk);
    check_rsp();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
